// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU op codes and forwarding select encoding.
package core_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned RWIDTH = 5;
  localparam int unsigned ALUCW  = 4;
  localparam int unsigned CNTW   = 32;

  localparam logic [ALUCW-1:0] ALUC_ADD  = 4'h0;
  localparam logic [ALUCW-1:0] ALUC_SUB  = 4'h1;
  localparam logic [ALUCW-1:0] ALUC_SLL  = 4'h2;
  localparam logic [ALUCW-1:0] ALUC_SLT  = 4'h3;
  localparam logic [ALUCW-1:0] ALUC_SLTU = 4'h4;
  localparam logic [ALUCW-1:0] ALUC_XOR  = 4'h5;
  localparam logic [ALUCW-1:0] ALUC_SRL  = 4'h6;
  localparam logic [ALUCW-1:0] ALUC_SRA  = 4'h7;
  localparam logic [ALUCW-1:0] ALUC_OR   = 4'h8;
  localparam logic [ALUCW-1:0] ALUC_AND  = 4'h9;
  localparam logic [ALUCW-1:0] ALUC_LUI  = 4'hA;
  localparam logic [ALUCW-1:0] ALUC_ADDW = 4'hB;
  localparam logic [ALUCW-1:0] ALUC_SUBW = 4'hC;
  localparam logic [ALUCW-1:0] ALUC_SLLW = 4'hD;
  localparam logic [ALUCW-1:0] ALUC_SRLW = 4'hE;
  localparam logic [ALUCW-1:0] ALUC_SRAW = 4'hF;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_EALU = 2'd1,
    FWD_MALU = 2'd2,
    FWD_MMO  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/forwarding inputs and EX-stage outputs of the ID/EX register.
// ID_EX_PERF_CNT_EN adds the stall/flush event counters.
interface id_ex_stage_if;
  import core_pkg::*;

  logic              dvalid;
  logic [XLEN-1:0]   dpc, dqa, dqb, dimm;
  logic [RWIDTH-1:0] drs1, drs2, drd;
  logic              duse1, duse2;
  logic [ALUCW-1:0]  daluc;
  logic              dasel, dbsel, dwreg, dm2reg, dwmem;
  logic [XLEN-1:0]   ealur, malu, mmo;
  logic              mwreg, mm2reg;
  logic [RWIDTH-1:0] mrd;
  logic              eflush;
  logic              dstall;
  logic              evalid;
  logic [XLEN-1:0]   epc, ea, eb, estore, eimm;
  logic [RWIDTH-1:0] erd;
  logic [ALUCW-1:0]  ealuc;
  logic              ewreg, em2reg, ewmem;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNTW-1:0]   stall_cnt, flush_cnt;
`endif

  modport master (
    output dvalid, dpc, dqa, dqb, dimm, drs1, drs2, drd, duse1, duse2, daluc,
           dasel, dbsel, dwreg, dm2reg, dwmem, ealur, malu, mmo, mwreg, mm2reg, mrd, eflush,
    input  dstall, evalid, epc, ea, eb, estore, eimm, erd, ealuc, ewreg, em2reg, ewmem
`ifdef ID_EX_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  dvalid, dpc, dqa, dqb, dimm, drs1, drs2, drd, duse1, duse2, daluc,
           dasel, dbsel, dwreg, dm2reg, dwmem, ealur, malu, mmo, mwreg, mm2reg, mrd, eflush,
    output dstall, evalid, epc, ea, eb, estore, eimm, erd, ealuc, ewreg, em2reg, ewmem
`ifdef ID_EX_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-source forwarding select and load-use detection (purely combinational).
module fwd_unit
  import core_pkg::*;
(
  input  logic [RWIDTH-1:0] rs,
  input  logic              rs_used,
  input  logic              dvalid,
  input  logic              evalid,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [RWIDTH-1:0] erd,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [RWIDTH-1:0] mrd,
  output fwd_sel_e          sel,
  output logic              luse
);

  // Youngest producer wins; x0 is never forwarded.
  always_comb begin
    sel  = FWD_REG;
    luse = 1'b0;
    if (rs != '0) begin
      if (evalid && ewreg && !em2reg && (erd == rs))
        sel = FWD_EALU;
      else if (mwreg && (mrd == rs))
        sel = mm2reg ? FWD_MMO : FWD_MALU;
      luse = dvalid && rs_used && evalid && ewreg && em2reg && (erd == rs);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM forwarding, load-use bubble and flush squash.
// ID_EX_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module id_ex_stage
  import core_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  fwd_sel_e        sel1, sel2;
  logic            luse1, luse2, luse;
  logic [XLEN-1:0] fwd1, fwd2;

  fwd_unit u_fwd1 (
    .rs(bus.drs1), .rs_used(bus.duse1), .dvalid(bus.dvalid),
    .evalid(bus.evalid), .ewreg(bus.ewreg), .em2reg(bus.em2reg), .erd(bus.erd),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mrd(bus.mrd),
    .sel(sel1), .luse(luse1)
  );

  fwd_unit u_fwd2 (
    .rs(bus.drs2), .rs_used(bus.duse2), .dvalid(bus.dvalid),
    .evalid(bus.evalid), .ewreg(bus.ewreg), .em2reg(bus.em2reg), .erd(bus.erd),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mrd(bus.mrd),
    .sel(sel2), .luse(luse2)
  );

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel, input logic [RWIDTH-1:0] rs,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] ealur,
                                               input logic [XLEN-1:0] malu,
                                               input logic [XLEN-1:0] mmo);
    case (sel)
      FWD_EALU: fwd_mux = ealur;
      FWD_MALU: fwd_mux = malu;
      FWD_MMO:  fwd_mux = mmo;
      default:  fwd_mux = (rs == '0) ? '0 : rf;
    endcase
  endfunction

  always_comb begin
    fwd1       = fwd_mux(sel1, bus.drs1, bus.dqa, bus.ealur, bus.malu, bus.mmo);
    fwd2       = fwd_mux(sel2, bus.drs2, bus.dqb, bus.ealur, bus.malu, bus.mmo);
    luse       = luse1 || luse2;
    bus.dstall = !rst && luse && !bus.eflush;
  end

  // Flush and load-use both insert a fully zeroed bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.eflush || luse) begin
      bus.evalid <= 1'b0;
      bus.ewreg  <= 1'b0;
      bus.em2reg <= 1'b0;
      bus.ewmem  <= 1'b0;
      bus.epc    <= '0;
      bus.ea     <= '0;
      bus.eb     <= '0;
      bus.estore <= '0;
      bus.eimm   <= '0;
      bus.erd    <= '0;
      bus.ealuc  <= '0;
    end else begin
      bus.evalid <= bus.dvalid;
      bus.ewreg  <= bus.dvalid && bus.dwreg;
      bus.em2reg <= bus.dvalid && bus.dm2reg;
      bus.ewmem  <= bus.dvalid && bus.dwmem;
      bus.epc    <= bus.dpc;
      bus.ea     <= bus.dasel ? bus.dpc : fwd1;
      bus.eb     <= bus.dbsel ? bus.dimm : fwd2;
      bus.estore <= fwd2;
      bus.eimm   <= bus.dimm;
      bus.erd    <= bus.drd;
      bus.ealuc  <= bus.daluc;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (luse && !bus.eflush) bus.stall_cnt <= bus.stall_cnt + CNTW'(1);
      if (bus.eflush)          bus.flush_cnt <= bus.flush_cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic against a reference model.
module tb_id_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Reference EX-stage state
  logic        m_valid, m_wreg, m_m2reg, m_wmem;
  logic [63:0] m_pc, m_a, m_b, m_store, m_imm;
  logic [4:0]  m_rd;
  logic [3:0]  m_aluc;
  logic [31:0] m_scnt, m_fcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    m_pc = 0; m_a = 0; m_b = 0; m_store = 0; m_imm = 0; m_rd = 0; m_aluc = 0;
  endtask

  function automatic logic [63:0] ref_fwd(input logic [4:0] r, input logic [63:0] rf);
    if (r == 0)                                       return 64'd0;
    if (m_valid && m_wreg && !m_m2reg && m_rd == r)   return bus.ealur;
    if (bus.mwreg && bus.mrd == r)                    return bus.mm2reg ? bus.mmo : bus.malu;
    return rf;
  endfunction

  task automatic idle();
    bus.dvalid = 0; bus.dpc = 0; bus.dqa = 0; bus.dqb = 0; bus.dimm = 0;
    bus.drs1 = 0; bus.drs2 = 0; bus.drd = 0; bus.duse1 = 0; bus.duse2 = 0;
    bus.daluc = 0; bus.dasel = 0; bus.dbsel = 0; bus.dwreg = 0; bus.dm2reg = 0; bus.dwmem = 0;
    bus.ealur = 0; bus.malu = 0; bus.mmo = 0; bus.mwreg = 0; bus.mm2reg = 0; bus.mrd = 0;
    bus.eflush = 0;
  endtask

  task automatic rand_inputs();
    bus.dvalid = ($urandom_range(0, 7) != 0);
    bus.dpc    = {$urandom, $urandom};
    bus.dimm   = {$urandom, $urandom};
    bus.drs1   = 5'($urandom_range(0, 3));
    bus.drs2   = 5'($urandom_range(0, 3));
    bus.drd    = 5'($urandom_range(0, 3));
    bus.dqa    = (bus.drs1 == 0) ? 64'd0 : {$urandom, $urandom};
    bus.dqb    = (bus.drs2 == 0) ? 64'd0 : {$urandom, $urandom};
    bus.duse1  = 1'($urandom); bus.duse2 = 1'($urandom);
    bus.daluc  = 4'($urandom);
    bus.dasel  = 1'($urandom); bus.dbsel = 1'($urandom);
    bus.dwreg  = 1'($urandom); bus.dm2reg = 1'($urandom); bus.dwmem = 1'($urandom);
    bus.ealur  = {$urandom, $urandom};
    bus.malu   = {$urandom, $urandom};
    bus.mmo    = {$urandom, $urandom};
    bus.mwreg  = 1'($urandom); bus.mm2reg = 1'($urandom);
    bus.mrd    = 5'($urandom_range(0, 3));
    bus.eflush = ($urandom_range(0, 7) == 0);
  endtask

  // One clock: check dstall before the edge, advance the model, check all registered outputs.
  task automatic cycle();
    logic        luse, st;
    logic [63:0] f1, f2;
    #1;
    luse = m_valid && m_wreg && m_m2reg && (m_rd != 0) && bus.dvalid &&
           ((bus.duse1 && m_rd == bus.drs1) || (bus.duse2 && m_rd == bus.drs2));
    st = !rst && luse && !bus.eflush;
    chk("dstall", 64'(bus.dstall), 64'(st));
    f1 = ref_fwd(bus.drs1, bus.dqa);
    f2 = ref_fwd(bus.drs2, bus.dqb);
    @(posedge clk);
    #1;
    if (rst) begin
      model_zero();
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (st) m_scnt++;
      if (bus.eflush) m_fcnt++;
      if (bus.eflush || luse) model_zero();
      else begin
        m_valid = bus.dvalid;
        m_wreg  = bus.dvalid & bus.dwreg;
        m_m2reg = bus.dvalid & bus.dm2reg;
        m_wmem  = bus.dvalid & bus.dwmem;
        m_pc    = bus.dpc;
        m_a     = bus.dasel ? bus.dpc : f1;
        m_b     = bus.dbsel ? bus.dimm : f2;
        m_store = f2;
        m_imm   = bus.dimm;
        m_rd    = bus.drd;
        m_aluc  = bus.daluc;
      end
    end
    chk("evalid", 64'(bus.evalid), 64'(m_valid));
    chk("ewreg", 64'(bus.ewreg), 64'(m_wreg));
    chk("em2reg", 64'(bus.em2reg), 64'(m_m2reg));
    chk("ewmem", 64'(bus.ewmem), 64'(m_wmem));
    chk("epc", bus.epc, m_pc);
    chk("ea", bus.ea, m_a);
    chk("eb", bus.eb, m_b);
    chk("estore", bus.estore, m_store);
    chk("eimm", bus.eimm, m_imm);
    chk("erd", 64'(bus.erd), 64'(m_rd));
    chk("ealuc", 64'(bus.ealuc), 64'(m_aluc));
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_scnt));
    chk("flush_cnt", 64'(bus.flush_cnt), 64'(m_fcnt));
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    model_zero();
    m_scnt = 0; m_fcnt = 0;

    // 1: reset with random inputs
    rst = 1;
    rand_inputs(); cycle();
    rand_inputs(); cycle();
    chk("rst_evalid", 64'(bus.evalid), 64'd0);
    chk("rst_ea", bus.ea, 64'd0);
    rst = 0;

    // 2: add x5,x1,x2 ; sub x6,x5,x3 with EX forward
    idle();
    bus.dvalid = 1; bus.drs1 = 1; bus.drs2 = 2; bus.drd = 5; bus.duse1 = 1; bus.duse2 = 1;
    bus.dwreg = 1; bus.daluc = ALUC_ADD; bus.dqa = 64'd1; bus.dqb = 64'd2;
    cycle();
    bus.drs1 = 5; bus.drs2 = 3; bus.drd = 6; bus.daluc = ALUC_SUB; bus.dqa = 64'h99;
    bus.dqb = 64'd3; bus.ealur = 64'h10;
    cycle();
    chk("t2_ea", bus.ea, 64'h10);
    chk("t2_evalid", 64'(bus.evalid), 64'd1);

    // 3: ld x7 ; add x8,x7,x1 -> one bubble then MEM load-data forward
    do_reset();
    bus.dvalid = 1; bus.drd = 7; bus.dwreg = 1; bus.dm2reg = 1; bus.drs1 = 2; bus.duse1 = 1;
    bus.dqa = 64'h100; bus.dimm = 64'h8;
    cycle();
    bus.dm2reg = 0; bus.drd = 8; bus.drs1 = 7; bus.drs2 = 1; bus.duse2 = 1;
    bus.dqa = 64'h77; bus.dqb = 64'h11; bus.daluc = ALUC_ADD;
    #1 chk("t3_dstall1", 64'(bus.dstall), 64'd1);
    cycle();
    chk("t3_bubble", 64'(bus.evalid), 64'd0);
    bus.mwreg = 1; bus.mm2reg = 1; bus.mrd = 7; bus.mmo = 64'hDEAD_BEEF;
    #1 chk("t3_dstall2", 64'(bus.dstall), 64'd0);
    cycle();
    chk("t3_ea", bus.ea, 64'hDEAD_BEEF);
    chk("t3_eb", bus.eb, 64'h11);
`ifdef ID_EX_PERF_CNT_EN
    chk("t3_stall_cnt", 64'(bus.stall_cnt), 64'd1);
`endif

    // 4: x0 write in EX is never forwarded
    do_reset();
    bus.dvalid = 1; bus.dwreg = 1; bus.drd = 0;
    cycle();
    bus.ealur = 64'h5; bus.drs1 = 0; bus.duse1 = 1; bus.dqa = 64'h0; bus.drd = 4;
    cycle();
    chk("t4_ea", bus.ea, 64'h0);

    // 5: flush coincident with load-use
    do_reset();
    bus.dvalid = 1; bus.drd = 7; bus.dwreg = 1; bus.dm2reg = 1;
    cycle();
    bus.dm2reg = 0; bus.drs1 = 7; bus.duse1 = 1; bus.drd = 9; bus.eflush = 1;
    #1 chk("t5_dstall", 64'(bus.dstall), 64'd0);
    cycle();
    chk("t5_evalid", 64'(bus.evalid), 64'd0);
    chk("t5_ewreg", 64'(bus.ewreg), 64'd0);

    // 6: store with immediate eb and MEM-forwarded store data
    do_reset();
    bus.mwreg = 1; bus.mrd = 9; bus.malu = 64'h1234;
    bus.dvalid = 1; bus.dwmem = 1; bus.drs2 = 9; bus.duse2 = 1; bus.dbsel = 1;
    bus.dimm = 64'h40; bus.dqb = 64'hBAD;
    cycle();
    chk("t6_eb", bus.eb, 64'h40);
    chk("t6_estore", bus.estore, 64'h1234);
    chk("t6_ewmem", 64'(bus.ewmem), 64'd1);

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
